vertblur: RTL and testbench
===========================

Name: vertblur

Overview:
- Vertical box-blur stage directly downstream of the horizontal blur filter in the write-back blur path.
- Consumes the horizontally blurred ARGB stream, one pixel per enabled cycle, in raster order.
- Averages each pixel with the same column in the previous 3 image rows, using 3 internal line buffers.
- Horizontal plus vertical together give the separable box blur used by blur mode (mode_wb = 3'b101).

Parameters:
IMG_WIDTH, 640, pixels per image row; sets line-buffer depth and the column-counter wrap point (minimum 2).
COL_W, $clog2(IMG_WIDTH), column-counter width.

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
wb_en  in  1  write-back pixel strobe
mode_wb  in  3  write-back mode; 3'b101 = blur
frame_start  in  1  pulse marking the first pixel of a new frame
data_in  in  32  horizontally blurred pixel {A,R,G,B}; A is ignored
blur_out  out  32  vertically blurred pixel {8'hFF,R,G,B}
out_valid  out  1  high for one cycle when blur_out carries a new pixel

Behaviour:
- Reset: n_rst is synchronous and active-low; clock is clk.
  - On reset: col = 0, row = 0, blur_out = 32'h0, out_valid = 0.
  - Line-buffer contents are not reset. Stale data is masked by the row counter (see taps).
- Accept condition: acc = wb_en && (mode_wb == 3'b101). Any other mode or a low wb_en is a stall.
- Stall:
  - col, row and line buffers hold.
  - out_valid = 0 and blur_out holds its last value.
- Effective position for a pixel:
  - If frame_start = 1 in the accept cycle, the pixel is treated as col = 0, row = 0.
  - Otherwise it uses the current col and row.
  - frame_start without acc clears col and row; the next accepted pixel is col 0, row 0.
- Line buffers LB1..LB3, each IMG_WIDTH x 24 bits. On acc at effective column c:
  - LB1[c] <= data_in[23:0]
  - LB2[c] <= old LB1[c]
  - LB3[c] <= old LB2[c]
  - All reads use pre-write values.
- Taps per channel (8 bits each):
  - t0 = data_in
  - t1 = LB1[c] if row >= 1, else 0
  - t2 = LB2[c] if row >= 2, else 0
  - t3 = LB3[c] if row >= 3, else 0
  - Masked rows contribute zero. This is the top-edge zero-fill rule, matching the horizontal stage's left-edge behaviour.
- Arithmetic:
  - sum = t0 + t1 + t2 + t3, 10 bits, no overflow possible.
  - Output channel = sum[9:2], truncating.
- Latency: 1 cycle.
  - In the cycle after acc: blur_out = {8'hFF, R, G, B} and out_valid = 1.
  - Back-to-back accepts produce back-to-back outputs.
- Counters, on acc:
  - col increments and wraps from IMG_WIDTH-1 to 0.
  - On wrap, row increments and saturates at 3.
  - The row counter only gates masking; it never stalls output.
- Reset asserted mid-row: the reset rules take priority over an accept in the same cycle. The next pixel is treated as col 0, row 0 with full masking.
- Partial final row: no flush behaviour. Outputs are produced only for accepted pixels.

Test Plan:
- Reset: hold n_rst = 0 for 2 cycles with wb_en = 1 -> blur_out = 32'h0, out_valid = 0. The first post-reset pixel is masked as row 0.
- Single row, IMG_WIDTH = 4: frame_start with the first pixel, then 4 pixels of 32'hFF808080, mode 3'b101 -> 4 outputs of 32'hFF202020, each one cycle after its input.
- Four rows of 32'hFFFFFFFF, IMG_WIDTH = 4 -> required outputs:
  - row 0: 32'hFF3F3F3F
  - row 1: 32'hFF7F7F7F
  - row 2: 32'hFFBFBFBF
  - row 3: 32'hFFFFFFFF
  - row 4: remains 32'hFFFFFFFF (row counter saturates).
- Stall mid-row: drop wb_en for 5 cycles after column 1 -> out_valid = 0 and blur_out held throughout; the resumed pixel lands in column 2 with the correct vertical sum.
- Mode gating: wb_en = 1 with mode_wb = 3'b100 for a full row -> no out_valid pulses, and a later blur row is unaffected.
- frame_start after 4 full rows of 32'hFFFFFFFF, followed by a row of 32'hFF000000 -> outputs 32'hFF000000. This proves stale buffers are masked. A mid-row n_rst followed by the same row gives the same result.

Source files
------------

// File: rtl/vertblur.sv
// Vertical box-blur stage: averages each ARGB pixel with the same column in the
// previous three rows, with rows above the top edge contributing zero.
module vertblur #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wb_en,
  input  logic [2:0]  mode_wb,
  input  logic        frame_start,
  input  logic [31:0] data_in,
  output logic [31:0] blur_out,
  output logic        out_valid
);

  localparam logic [2:0]       MODE_BLUR = 3'b101;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);

  logic [23:0] lb1 [IMG_WIDTH];
  logic [23:0] lb2 [IMG_WIDTH];
  logic [23:0] lb3 [IMG_WIDTH];

  logic [COL_W-1:0] col;
  logic [1:0]       row;

  logic             acc_p0;
  logic [COL_W-1:0] col_p0;
  logic [1:0]       row_p0;
  logic [23:0]      pix_p0;
  logic [23:0]      t1_p0;
  logic [23:0]      t2_p0;
  logic [23:0]      t3_p0;

  // Alpha is replaced by 8'hFF on output, so the incoming alpha byte is dropped.
  logic unused_alpha;
  assign unused_alpha = ^data_in[31:24];

  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return 8'(sum >> 2);
  endfunction

  // Stage p0: effective position, buffer reads (pre-write) and top-edge masking
  always_comb begin
    acc_p0 = wb_en && (mode_wb == MODE_BLUR);
    col_p0 = frame_start ? '0 : col;
    row_p0 = frame_start ? 2'd0 : row;
    pix_p0 = data_in[23:0];
    t1_p0  = (row_p0 >= 2'd1) ? lb1[col_p0] : 24'h0;
    t2_p0  = (row_p0 >= 2'd2) ? lb2[col_p0] : 24'h0;
    t3_p0  = (row_p0 == 2'd3) ? lb3[col_p0] : 24'h0;
  end

  // Line buffers are never cleared; the row counter masks stale contents.
  always_ff @(posedge clk) begin
    if (n_rst && acc_p0) begin
      lb1[col_p0] <= pix_p0;
      lb2[col_p0] <= lb1[col_p0];
      lb3[col_p0] <= lb2[col_p0];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      col <= '0;
      row <= 2'd0;
    end else if (acc_p0) begin
      if (col_p0 == COL_LAST) begin
        col <= '0;
        row <= (row_p0 == 2'd3) ? 2'd3 : row_p0 + 2'd1;
      end else begin
        col <= col_p0 + 1'b1;
        row <= row_p0;
      end
    end else if (frame_start) begin
      col <= '0;
      row <= 2'd0;
    end
  end

  // Stage p1: registered average, one cycle after the accept
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blur_out  <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= acc_p0;
      if (acc_p0) begin
        blur_out <= {8'hFF,
                     avg4(pix_p0[23:16], t1_p0[23:16], t2_p0[23:16], t3_p0[23:16]),
                     avg4(pix_p0[15:8],  t1_p0[15:8],  t2_p0[15:8],  t3_p0[15:8]),
                     avg4(pix_p0[7:0],   t1_p0[7:0],   t2_p0[7:0],   t3_p0[7:0])};
      end
    end
  end

endmodule

// File: tb/tb_vertblur.sv
// Directed bench for vertblur with a 4-pixel image width; expected pixels are
// hand-computed box averages with zero-filled rows above the top edge.
module tb_vertblur;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wb_en;
  logic [2:0]  mode_wb;
  logic        frame_start;
  logic [31:0] data_in;
  logic [31:0] blur_out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  vertblur #(.IMG_WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst), .wb_en(wb_en), .mode_wb(mode_wb),
    .frame_start(frame_start), .data_in(data_in),
    .blur_out(blur_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Present one accepted pixel for exactly one clock; returns 1 ns after the edge.
  task automatic push(input logic [31:0] d, input logic fs);
    data_in     = d;
    frame_start = fs;
    wb_en       = 1'b1;
    mode_wb     = 3'b101;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    wb_en       = 1'b0;
  endtask

  task automatic idle();
    wb_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rows(input int n, input logic [31:0] d);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < W; c++)
        push(d, (r == 0 && c == 0));
  endtask

  task automatic test_reset();
    n_rst = 1'b0; wb_en = 1'b1; mode_wb = 3'b101; frame_start = 1'b0;
    data_in = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (blur_out !== 32'h0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got out=%h vld=%b want out=00000000 vld=0", i, blur_out, out_valid);
      end
    end
    n_rst = 1'b1;
    wb_en = 1'b0;
    push(32'hFFFFFFFF, 1'b0);
    total++;
    if (blur_out !== 32'hFF3F3F3F || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_pixel: got out=%h vld=%b want out=ff3f3f3f vld=1", blur_out, out_valid);
    end
  endtask

  task automatic test_single_row();
    for (int c = 0; c < W; c++) begin
      push(32'hFF808080, (c == 0));
      total++;
      if (blur_out !== 32'hFF202020 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL single_row col%0d: got out=%h vld=%b want out=ff202020 vld=1", c, blur_out, out_valid);
      end
    end
    idle();
    total++;
    if (blur_out !== 32'hFF202020 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_row_after: got out=%h vld=%b want out=ff202020 vld=0", blur_out, out_valid);
    end
  endtask

  task automatic test_four_rows();
    logic [31:0] exp_row [5];
    exp_row[0] = 32'hFF3F3F3F; exp_row[1] = 32'hFF7F7F7F; exp_row[2] = 32'hFFBFBFBF;
    exp_row[3] = 32'hFFFFFFFF; exp_row[4] = 32'hFFFFFFFF;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) begin
        push(32'hFFFFFFFF, (r == 0 && c == 0));
        total++;
        if (blur_out !== exp_row[r] || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL four_rows r%0d c%0d: got out=%h vld=%b want out=%h vld=1", r, c, blur_out, out_valid, exp_row[r]);
        end
      end
  endtask

  task automatic test_stall();
    for (int c = 0; c < W; c++) push(32'hFF404040, (c == 0));
    for (int c = 0; c < 2; c++) begin
      push(32'hFF808080, 1'b0);
      total++;
      if (blur_out !== 32'hFF303030 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_pre c%0d: got out=%h vld=%b want out=ff303030 vld=1", c, blur_out, out_valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      total++;
      if (blur_out !== 32'hFF303030 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: got out=%h vld=%b want out=ff303030 vld=0", i, blur_out, out_valid);
      end
    end
    // Alpha 00 must be replaced by FF; column 2 row above holds 0x40.
    push(32'h00200820, 1'b0);
    total++;
    if (blur_out !== 32'hFF181218 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_resume: got out=%h vld=%b want out=ff181218 vld=1", blur_out, out_valid);
    end
  endtask

  task automatic test_mode_gating();
    for (int i = 0; i < W; i++) begin
      data_in = 32'hFFFFFFFF; wb_en = 1'b1; mode_wb = 3'b100;
      @(posedge clk);
      #1;
      total++;
      if (blur_out !== 32'hFF181218 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mode_gate cyc%0d: got out=%h vld=%b want out=ff181218 vld=0", i, blur_out, out_valid);
      end
    end
    wb_en = 1'b0;
    push(32'hFF808080, 1'b0);
    total++;
    if (blur_out !== 32'hFF303030 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mode_gate_resume: got out=%h vld=%b want out=ff303030 vld=1", blur_out, out_valid);
    end
  endtask

  task automatic test_frame_restart();
    fill_rows(4, 32'hFFFFFFFF);
    for (int c = 0; c < W; c++) begin
      push(32'hFF000000, (c == 0));
      total++;
      if (blur_out !== 32'hFF000000 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL frame_restart c%0d: got out=%h vld=%b want out=ff000000 vld=1", c, blur_out, out_valid);
      end
    end
  endtask

  task automatic test_reset_midrow();
    fill_rows(4, 32'hFFFFFFFF);
    push(32'hFFFFFFFF, 1'b0);
    push(32'hFFFFFFFF, 1'b0);
    n_rst = 1'b0; wb_en = 1'b1; mode_wb = 3'b101; data_in = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    total++;
    if (blur_out !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_midrow_hold: got out=%h vld=%b want out=00000000 vld=0", blur_out, out_valid);
    end
    n_rst = 1'b1;
    wb_en = 1'b0;
    for (int c = 0; c < W; c++) begin
      push(32'hFF000000, 1'b0);
      total++;
      if (blur_out !== 32'hFF000000 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL reset_midrow c%0d: got out=%h vld=%b want out=ff000000 vld=1", c, blur_out, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_four_rows();
    test_stall();
    test_mode_gating();
    test_frame_restart();
    test_reset_midrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
